// File: rtl/countdown16.sv
// Loadable countdown timer: decrements on qualified tick, pulses done at terminal count.
// Define COUNTDOWN16_AUTO_RELOAD_EN for periodic reload; otherwise one-shot.
module countdown16 #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in,
  input  logic             load,
  input  logic             start,
  input  logic             stop,
  input  logic             tick,
  output logic [WIDTH-1:0] out,
  output logic             running,
  output logic             done
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

`ifdef COUNTDOWN16_AUTO_RELOAD_EN
  localparam bit AutoReload = 1'b1;
`else
  localparam bit AutoReload = 1'b0;
`endif

  logic [WIDTH-1:0] out_q, out_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic [0:0]       state_q, state_d;
  logic             done_q, done_d;

  always_comb begin
    out_d    = out_q;
    reload_d = reload_q;
    state_d  = state_q;
    done_d   = 1'b0;
    if (load) begin
      out_d    = in;
      reload_d = in;
      state_d  = IDLE;
    end else if (stop) begin
      // stop outranks start, so stop+start in IDLE is also a no-op
      if (state_q == RUN) state_d = IDLE;
    end else if (start && state_q == IDLE) begin
      if (out_q == '0) done_d = 1'b1;
      else             state_d = RUN;
    end else if (state_q == RUN && tick) begin
      if (out_q == WIDTH'(1)) begin
        done_d = 1'b1;
        if (AutoReload) begin
          out_d = reload_q;
        end else begin
          out_d   = '0;
          state_d = IDLE;
        end
      end else if (out_q != '0) begin
        out_d = out_q - WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_q    <= '0;
      reload_q <= '0;
      state_q  <= IDLE;
      done_q   <= 1'b0;
    end else begin
      out_q    <= out_d;
      reload_q <= reload_d;
      state_q  <= state_d;
      done_q   <= done_d;
    end
  end

  assign out     = out_q;
  assign running = (state_q == RUN);
  assign done    = done_q;

endmodule

// File: tb/tb_countdown16.sv
// Self-checking bench for countdown16: directed scenarios plus random commands vs. a behavioural model.
module tb_countdown16;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] in = '0;
  logic        load = 1'b0, start = 1'b0, stop = 1'b0, tick = 1'b0;
  logic [15:0] out;
  logic        running, done;

  int errors = 0;
  int checks = 0;

  // behavioural model state
  int unsigned m_count = 0;
  int unsigned m_period = 0;
  bit          m_active = 0;
  bit          m_pulse = 0;

  countdown16 #(.WIDTH(16)) dut (
    .clk(clk), .reset(reset), .in(in), .load(load), .start(start),
    .stop(stop), .tick(tick), .out(out), .running(running), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".out"}, out, 16'(m_count));
    chk({tag, ".running"}, {15'b0, running}, {15'b0, m_active});
    chk({tag, ".done"}, {15'b0, done}, {15'b0, m_pulse});
  endtask

  // One clock edge of reference behaviour, expressed as timer semantics.
  task automatic model_edge(input bit ld, input bit st, input bit sp, input bit tk, input logic [15:0] val);
    m_pulse = 0;
    if (ld) begin
      m_count = val; m_period = val; m_active = 0;
    end else if (sp) begin
      m_active = 0;
    end else if (st && !m_active) begin
      if (m_count == 0) m_pulse = 1;
      else m_active = 1;
    end else if (m_active && tk && m_count > 0) begin
      m_count = m_count - 1;
      if (m_count == 0) begin
        m_pulse = 1;
`ifdef COUNTDOWN16_AUTO_RELOAD_EN
        m_count = m_period;
`else
        m_active = 0;
`endif
      end
    end
  endtask

  task automatic step(input string tag, input bit ld, input bit st, input bit sp, input bit tk,
                      input logic [15:0] val);
    load = ld; start = st; stop = sp; tick = tk; in = val;
    @(posedge clk);
    model_edge(ld, st, sp, tk, val);
    #1 chk_all(tag);
    @(negedge clk);
  endtask

  initial begin
    // reset held with load asserted: outputs stay cleared
    @(negedge clk);
    reset = 1'b1; load = 1'b1; in = 16'h1234;
    #1;
    chk("rst_async.out", out, 16'h0000);
    chk("rst_async.running", {15'b0, running}, 16'h0000);
    chk("rst_async.done", {15'b0, done}, 16'h0000);
    @(posedge clk); #1;
    chk("rst_edge.out", out, 16'h0000);
    @(negedge clk);
    reset = 1'b0;
    step("rst_release_load", 1, 0, 0, 0, 16'h1234);
    chk("rst_release_const", out, 16'h1234);

    // load 5, start with tick high (no decrement on start edge), then count down
    step("l5", 1, 0, 0, 1, 16'd5);
    step("l5_start", 0, 1, 0, 1, 16'd0);
    chk("l5_start_hold", out, 16'd5);
    for (int i = 0; i < 7; i++) step("l5_tick", 0, 0, 0, 1, 16'd0);

    // stop+start on the same edge, then resume
    step("l10", 1, 0, 0, 0, 16'd10);
    step("l10_start", 0, 1, 0, 0, 16'd0);
    for (int i = 0; i < 4; i++) step("l10_tick", 0, 0, 0, 1, 16'd0);
    step("l10_stopstart", 0, 1, 1, 1, 16'd0);
    chk("l10_held_const", out, 16'd6);
    step("l10_idle_tick", 0, 0, 0, 1, 16'd0);
    step("l10_resume", 0, 1, 0, 1, 16'd0);
    for (int i = 0; i < 7; i++) step("l10_tick2", 0, 0, 0, 1, 16'd0);

    // zero-length count
    step("l0", 1, 0, 0, 0, 16'd0);
    step("l0_start", 0, 1, 0, 1, 16'd0);
    chk("l0_done_const", {15'b0, done}, 16'd1);
    step("l0_after", 0, 0, 0, 1, 16'd0);

    // load during run at out=2
    step("l4", 1, 0, 0, 0, 16'd4);
    step("l4_start", 0, 1, 0, 0, 16'd0);
    step("l4_t", 0, 0, 0, 1, 16'd0);
    step("l4_t", 0, 0, 0, 1, 16'd0);
    step("l7_midrun", 1, 0, 0, 1, 16'd7);
    chk("l7_midrun_const", out, 16'd7);

    // tick toggling in RUN, then tick in IDLE
    step("tg_start", 0, 1, 0, 0, 16'd0);
    for (int i = 0; i < 6; i++) step("tg_toggle", 0, 0, 0, (i % 2) == 0, 16'd0);
    step("tg_stop", 0, 0, 1, 1, 16'd0);
    step("tg_idle_tick", 0, 0, 0, 1, 16'd0);

    // reload value of 1: back-to-back terminal in reload build
    step("l1", 1, 0, 0, 0, 16'd1);
    step("l1_start", 0, 1, 0, 0, 16'd0);
    for (int i = 0; i < 4; i++) step("l1_tick", 0, 0, 0, 1, 16'd0);

    // randomized command mix with small counts so terminal events occur often
    for (int i = 0; i < 400; i++) begin
      automatic bit ld = ($urandom_range(0, 99) < 6);
      automatic bit st = ($urandom_range(0, 99) < 15);
      automatic bit sp = ($urandom_range(0, 99) < 5);
      automatic bit tk = ($urandom_range(0, 99) < 65);
      automatic logic [15:0] v = ($urandom_range(0, 9) == 0) ? 16'($urandom) : 16'($urandom_range(0, 12));
      step("rand", ld, st, sp, tk, v);
    end

    // asynchronous reset mid-count
    step("ar_load", 1, 0, 0, 0, 16'd9);
    step("ar_start", 0, 1, 0, 0, 16'd0);
    for (int i = 0; i < 3; i++) step("ar_tick", 0, 0, 0, 1, 16'd0);
    #2 reset = 1'b1;
    #1;
    m_count = 0; m_period = 0; m_active = 0; m_pulse = 0;
    chk_all("ar_async");
    @(negedge clk);
    reset = 1'b0;
    step("ar_after", 0, 0, 0, 1, 16'd0);
    step("ar_start0", 0, 1, 0, 1, 16'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
